// File: rtl/camera_qsys_ocm_arb_pkg.sv
// Shared types and constants for the camera on-chip-memory arbiter.
package camera_qsys_ocm_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int OCM_DEPTH = 32000;
  localparam int OCM_AW = 15;
  localparam logic [31:0] OOR_READ_DATA = 32'h0000_0000;
endpackage

// File: rtl/camera_qsys_ocm_arb_stats.sv
// Grant and stall counters for the OCM arbiter; wrap at 2^32, clear wins over increment.
module camera_qsys_ocm_arb_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        inc_grant0,
  input  logic        inc_grant1,
  input  logic        inc_stall,
  output logic [31:0] grant0,
  output logic [31:0] grant1,
  output logic [31:0] stall
);
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      grant0 <= '0;
      grant1 <= '0;
      stall  <= '0;
    end else begin
      if (inc_grant0) grant0 <= grant0 + 32'd1;
      if (inc_grant1) grant1 <= grant1 + 32'd1;
      if (inc_stall)  stall  <= stall + 32'd1;
    end
  end
endmodule

// File: rtl/camera_qsys_ocm_arbiter.sv
// Round-robin arbiter sharing a 1-cycle-latency single-port OCM between two Avalon-MM masters.
// Optional statistics counters are built when OCM_ARB_STATS_EN is defined.
module camera_qsys_ocm_arbiter
  import camera_qsys_ocm_arb_pkg::*;
#(
  parameter int DEPTH     = OCM_DEPTH,
  parameter int AW        = OCM_AW,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] m0_address,
  input  logic [3:0]    m0_byteenable,
  input  logic          m0_read,
  input  logic          m0_write,
  input  logic [31:0]   m0_writedata,
  output logic          m0_waitrequest,
  output logic [31:0]   m0_readdata,
  output logic          m0_readdatavalid,
  input  logic [AW-1:0] m1_address,
  input  logic [3:0]    m1_byteenable,
  input  logic          m1_read,
  input  logic          m1_write,
  input  logic [31:0]   m1_writedata,
  output logic          m1_waitrequest,
  output logic [31:0]   m1_readdata,
  output logic          m1_readdatavalid,
  output logic [AW-1:0] mem_address,
  output logic [3:0]    mem_byteenable,
  output logic          mem_chipselect,
  output logic          mem_write,
  output logic [31:0]   mem_writedata,
  output logic          mem_clken,
  output logic          mem_reset_req,
  input  logic [31:0]   mem_readdata,
  input  logic          stat_clear,
  output logic [31:0]   stat_grant0,
  output logic [31:0]   stat_grant1,
  output logic [31:0]   stat_stall,
  output logic [1:0]    dbg_state
);
  localparam int HW = $clog2(MAX_BURST + 1);
  localparam logic [HW-1:0] MAX_HOLD = HW'(MAX_BURST);
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

  arb_state_t     state;
  logic [HW-1:0]  hold_cnt;
  logic           rr_last;
  logic           tag_valid, tag_id, tag_oor;

  logic           req0, req1;
  logic           sel_valid, sel_id;
  logic [AW-1:0]  sel_addr;
  logic           sel_write, in_range, own_match;
  logic [31:0]    rdata;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_comb begin
    sel_valid = 1'b0;
    sel_id    = 1'b0;
    unique case (state)
      OWN0: begin
        if (req0 && (hold_cnt < MAX_HOLD || !req1)) begin
          sel_valid = 1'b1;
        end else if (req1) begin
          sel_valid = 1'b1;
          sel_id    = 1'b1;
        end
      end
      OWN1: begin
        if (req1 && (hold_cnt < MAX_HOLD || !req0)) begin
          sel_valid = 1'b1;
          sel_id    = 1'b1;
        end else if (req0) begin
          sel_valid = 1'b1;
        end
      end
      default: begin
        // On a tie, the master that was not granted last wins.
        sel_valid = req0 | req1;
        sel_id    = (req0 && req1) ? ~rr_last : req1;
      end
    endcase
    if (reset) sel_valid = 1'b0;
  end

  assign sel_addr  = sel_id ? m1_address : m0_address;
  assign sel_write = sel_id ? m1_write : m0_write;
  assign in_range  = {1'b0, sel_addr} < DEPTH_W;
  assign own_match = (state == OWN0 && !sel_id) || (state == OWN1 && sel_id);

  // Avalon handshake: a transfer is accepted in the cycle where the master requests
  // and its waitrequest is 0; a non-requesting master sees waitrequest 0 except in reset.
  assign m0_waitrequest = reset | (req0 & ~(sel_valid & ~sel_id));
  assign m1_waitrequest = reset | (req1 & ~(sel_valid & sel_id));

  assign mem_chipselect = sel_valid & in_range;
  assign mem_write      = mem_chipselect & sel_write;
  assign mem_address    = sel_valid ? sel_addr : '0;
  assign mem_byteenable = sel_valid ? (sel_id ? m1_byteenable : m0_byteenable) : 4'h0;
  assign mem_writedata  = sel_valid ? (sel_id ? m1_writedata : m0_writedata) : 32'h0;
  assign mem_clken      = 1'b1;
  assign mem_reset_req  = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      rr_last   <= 1'b1;
      tag_valid <= 1'b0;
      tag_id    <= 1'b0;
      tag_oor   <= 1'b0;
    end else begin
      tag_valid <= sel_valid & ~sel_write;
      tag_id    <= sel_id;
      tag_oor   <= ~in_range;
      if (sel_valid) begin
        state    <= sel_id ? OWN1 : OWN0;
        rr_last  <= sel_id;
        if (own_match) hold_cnt <= (hold_cnt == MAX_HOLD) ? hold_cnt : hold_cnt + 1'b1;
        else           hold_cnt <= HW'(1);
      end else begin
        state    <= IDLE;
        hold_cnt <= '0;
      end
    end
  end

  // Out-of-range reads never touched the memory, so substitute the fixed value.
  assign rdata            = tag_oor ? OOR_READ_DATA : mem_readdata;
  assign m0_readdata      = rdata;
  assign m1_readdata      = rdata;
  assign m0_readdatavalid = tag_valid & ~tag_id & ~reset;
  assign m1_readdatavalid = tag_valid & tag_id & ~reset;
  assign dbg_state        = state;

`ifdef OCM_ARB_STATS_EN
  logic stall_any;
  assign stall_any = ~reset & ((req0 & m0_waitrequest) | (req1 & m1_waitrequest));

  camera_qsys_ocm_arb_stats u_stats (
    .clk        (clk),
    .reset      (reset),
    .clear      (stat_clear),
    .inc_grant0 (sel_valid & ~sel_id),
    .inc_grant1 (sel_valid & sel_id),
    .inc_stall  (stall_any),
    .grant0     (stat_grant0),
    .grant1     (stat_grant1),
    .stall      (stat_stall)
  );
`else
  logic unused_stat_clear;
  assign unused_stat_clear = stat_clear;
  assign stat_grant0 = 32'h0;
  assign stat_grant1 = 32'h0;
  assign stat_stall  = 32'h0;
`endif
endmodule

// File: tb/tb_camera_qsys_ocm_arbiter.sv
// Directed self-checking bench for camera_qsys_ocm_arbiter with a behavioural 1-cycle OCM.
module tb_camera_qsys_ocm_arbiter;
  logic        clk, reset;
  logic [14:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken, mem_reset_req;
  logic [31:0] mem_writedata, mem_readdata;
  logic        stat_clear;
  logic [31:0] stat_grant0, stat_grant1, stat_stall;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  camera_qsys_ocm_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_reset_req(mem_reset_req), .mem_readdata(mem_readdata),
    .stat_clear(stat_clear), .stat_grant0(stat_grant0), .stat_grant1(stat_grant1),
    .stat_stall(stat_stall), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // OCM model: words at or above 32000 read back a marker, and any write there is flagged.
  logic [31:0] mem_model [0:32767];
  logic        oor_write_seen = 1'b0;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        if (mem_address >= 15'd32000) oor_write_seen <= 1'b1;
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem_model[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= (mem_address >= 15'd32000) ? 32'hDEAD_BEEF : mem_model[mem_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
  endtask

  task automatic drive(input int m, input logic rd, input logic wr, input logic [14:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  task automatic wr_op(input int m, input logic [14:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic exp_cs);
    drive(m, 1'b0, 1'b1, a, d, be);
    @(negedge clk);
    check("wr_accept", (m == 0) ? m0_waitrequest : m1_waitrequest, 0);
    check("wr_cs", mem_chipselect, exp_cs);
    check("wr_mem_write", mem_write, exp_cs);
    tick();
    clr_inputs();
  endtask

  task automatic rd_op(input int m, input logic [14:0] a, input logic [31:0] exp_d,
                       input logic exp_cs);
    drive(m, 1'b1, 1'b0, a, 32'h0, 4'hF);
    @(negedge clk);
    check("rd_accept", (m == 0) ? m0_waitrequest : m1_waitrequest, 0);
    check("rd_cs", mem_chipselect, exp_cs);
    check("rd_no_early_valid", {m1_readdatavalid, m0_readdatavalid}, 0);
    tick();
    clr_inputs();
    @(negedge clk);
    check("rd_valid", {m1_readdatavalid, m0_readdatavalid}, (m == 0) ? 2'b01 : 2'b10);
    check("rd_data", (m == 0) ? m0_readdata : m1_readdata, exp_d);
    tick();
  endtask

  // scoreboard for the contention run: expected grant per cycle
  logic [0:0] exp_q[$];

  initial begin
    logic prev;
    clr_inputs();
    stat_clear = 0;
    reset = 1;

    // Reset: requests present but everything held off.
    m0_read = 1; m1_read = 1;
    @(negedge clk);
    check("rst_wait", {m1_waitrequest, m0_waitrequest}, 2'b11);
    check("rst_rvalid", {m1_readdatavalid, m0_readdatavalid}, 0);
    check("rst_cs", mem_chipselect, 0);
    check("rst_addr", {17'h0, mem_address}, 0);
    check("clken", mem_clken, 1);
    check("reset_req", mem_reset_req, 0);
    check("rst_state", {30'h0, dbg_state}, 0);
    tick(); tick();
    reset = 0;
    clr_inputs();
    @(negedge clk);
    check("idle_wait", {m1_waitrequest, m0_waitrequest}, 2'b00);
    check("idle_cs", mem_chipselect, 0);

    // Write by m0, read back by m1.
    wr_op(0, 15'h0010, 32'h1234_5678, 4'hF, 1'b1);
    rd_op(1, 15'h0010, 32'h1234_5678, 1'b1);

    // Partial byte-lane write.
    wr_op(0, 15'h0020, 32'hFFFF_FFFF, 4'hF, 1'b1);
    wr_op(0, 15'h0020, 32'hAABB_CCDD, 4'b0011, 1'b1);
    rd_op(0, 15'h0020, 32'hFFFF_CCDD, 1'b1);

    // Last valid word, then out-of-range accesses.
    wr_op(1, 15'h7CFF, 32'hCAFE_F00D, 4'hF, 1'b1);
    rd_op(1, 15'h7CFF, 32'hCAFE_F00D, 1'b1);
    rd_op(0, 15'h7D00, 32'h0, 1'b0);
    wr_op(0, 15'h7D00, 32'h5555_5555, 4'hF, 1'b0);
    rd_op(1, 15'h7FFF, 32'h0, 1'b0);
    check("oor_write_dropped", oor_write_seen, 0);

    // Reset the cycle after a read is accepted: the response is dropped.
    drive(1, 1'b1, 1'b0, 15'h0010, 32'h0, 4'hF);
    @(negedge clk);
    check("pre_rst_accept", m1_waitrequest, 0);
    tick();
    clr_inputs();
    reset = 1;
    @(negedge clk);
    check("rst_drop_valid", {m1_readdatavalid, m0_readdatavalid}, 0);
    tick();
    reset = 0;
    @(negedge clk);
    check("post_rst_valid", {m1_readdatavalid, m0_readdatavalid}, 0);
    tick();

    // Contention from IDLE: m0 first, then bursts of 8 alternate.
    for (int k = 0; k < 24; k++) exp_q.push_back(((k / 8) % 2 == 1) ? 1'b1 : 1'b0);
    drive(0, 1'b1, 1'b0, 15'h0010, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 15'h0020, 32'h0, 4'hF);
    prev = 1'b0;
    for (int k = 0; k < 24; k++) begin
      logic g;
      g = exp_q.pop_front();
      @(negedge clk);
      check("rr_grant", {m1_waitrequest, m0_waitrequest}, g ? 2'b01 : 2'b10);
      if (k == 0) check("rr_start_state", {30'h0, dbg_state}, 0);
      if (k > 0) begin
        check("rr_rvalid", {m1_readdatavalid, m0_readdatavalid}, prev ? 2'b10 : 2'b01);
        check("rr_rdata", prev ? m1_readdata : m0_readdata,
              prev ? 32'hFFFF_CCDD : 32'h1234_5678);
      end
      prev = g;
      tick();
    end

    // m0 alone keeps going past the burst limit; a new m1 request wins at once.
    m1_read = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("solo_grant", m0_waitrequest, 0);
      tick();
    end
    m1_read = 1;
    @(negedge clk);
    check("sat_handover", {m1_waitrequest, m0_waitrequest}, 2'b01);
    tick();
    clr_inputs();
    tick(); tick();

`ifdef OCM_ARB_STATS_EN
    stat_clear = 1;
    tick();
    stat_clear = 0;
    @(negedge clk);
    check("stat_cleared", stat_grant0 | stat_grant1 | stat_stall, 0);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(0, 1'b1, 1'b0, 15'h0010, 32'h0, 4'hF);
      m1_read = (k >= 2 && k < 5);
      tick();
    end
    clr_inputs();
    @(negedge clk);
    check("stat_grant0", stat_grant0, 10);
    check("stat_grant1", stat_grant1, 0);
    check("stat_stall", stat_stall, 3);
    tick();
    drive(0, 1'b1, 1'b0, 15'h0010, 32'h0, 4'hF);
    stat_clear = 1;
    tick();
    clr_inputs();
    stat_clear = 0;
    @(negedge clk);
    check("stat_clear_wins", stat_grant0 | stat_grant1 | stat_stall, 0);
    tick();
`else
    @(negedge clk);
    check("stat_off_grant0", stat_grant0, 0);
    check("stat_off_grant1", stat_grant1, 0);
    check("stat_off_stall", stat_stall, 0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
